// File: rtl/instruction_fetch.sv
// instruction_fetch: fetch stage of the 16-bit core.
// Owns the PC, addresses the combinational instruction ROM and registers the
// returned word into a single fetch slot that decode consumes.
//
// Handshake: the slot is offered to decode while if_valid is 1; a transfer
// happens on a rising edge where if_valid and id_ready are both 1. While
// if_valid is 1 and id_ready is 0, if_instr and if_pc hold stable. The slot
// may be refilled on the same edge it transfers (free = !if_valid || id_ready).
module instruction_fetch #(
    parameter int              W           = 16,
    parameter int              DEPTH       = 16,
    parameter logic [W-1:0]    RESET_PC    = '0,
    parameter logic [W-1:0]    HALT_OPCODE = '1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    output logic [W-1:0] pc,
    input  logic [W-1:0] instruction,
    input  logic         redirect_valid,
    input  logic [W-1:0] redirect_pc,
    output logic         if_valid,
    output logic [W-1:0] if_instr,
    output logic [W-1:0] if_pc,
    input  logic         id_ready,
    output logic         halted,
    output logic         fault,
    output logic [W-1:0] fetch_count
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } state_t;

    // First PC value that lies outside the ROM.
    localparam logic [W-1:0] PC_LIMIT  = W'(DEPTH);
    localparam logic [W-1:0] COUNT_MAX = '1;

    state_t       state_q, state_d;
    logic [W-1:0] pc_q, pc_d;
    logic         if_valid_q, if_valid_d;
    logic [W-1:0] if_instr_q, if_instr_d;
    logic [W-1:0] if_pc_q, if_pc_d;
    logic         fault_q, fault_d;
    logic [W-1:0] fetch_count_q, fetch_count_d;

    logic         slot_free;
    logic         slot_xfer;
    logic         pc_out_of_range;
    logic [W-1:0] fetch_count_inc;

    assign slot_free       = !if_valid_q || id_ready;
    assign slot_xfer       = if_valid_q && id_ready;
    assign pc_out_of_range = (pc_q >= PC_LIMIT);
    // Saturating increment: the counter sticks at all-ones.
    assign fetch_count_inc = (fetch_count_q == COUNT_MAX) ? fetch_count_q
                                                          : fetch_count_q + 1'b1;

    // Next-state and datapath decisions; everything holds unless a rule fires.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        if_valid_d    = if_valid_q;
        if_instr_d    = if_instr_q;
        if_pc_d       = if_pc_q;
        fault_d       = fault_q;
        fetch_count_d = fetch_count_q;

        case (state_q)
            S_IDLE: begin
                // redirect_valid has no meaning before fetch has started.
                if (start) begin
                    state_d    = S_RUN;
                    pc_d       = RESET_PC;
                    fault_d    = 1'b0;
                    if_valid_d = 1'b0;
                end else if (slot_xfer) begin
                    if_valid_d = 1'b0;
                end
            end

            S_RUN: begin
                // start is ignored while running.
                if (redirect_valid) begin
                    // Flush regardless of id_ready; the wrong-path word is dropped.
                    pc_d       = redirect_pc;
                    if_valid_d = 1'b0;
                end else if (pc_out_of_range) begin
                    // Stop without touching the ROM; a pending slot may still drain.
                    fault_d = 1'b1;
                    state_d = S_HALT;
                    if (slot_xfer) begin
                        if_valid_d = 1'b0;
                    end
                end else if (slot_free) begin
                    if_instr_d    = instruction;
                    if_pc_d       = pc_q;
                    if_valid_d    = 1'b1;
                    fetch_count_d = fetch_count_inc;
                    if (instruction == HALT_OPCODE) begin
                        // The halt word is delivered; pc stays on it.
                        state_d = S_HALT;
                    end else begin
                        pc_d = pc_q + 1'b1;
                    end
                end
            end

            S_HALT: begin
                // redirect_valid is ignored; only start resumes fetching.
                if (start) begin
                    state_d    = S_RUN;
                    pc_d       = RESET_PC;
                    fault_d    = 1'b0;
                    if_valid_d = 1'b0;
                end else if (slot_xfer) begin
                    if_valid_d = 1'b0;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers, cleared immediately by the async reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            pc_q          <= RESET_PC;
            if_valid_q    <= 1'b0;
            if_instr_q    <= '0;
            if_pc_q       <= '0;
            fault_q       <= 1'b0;
            fetch_count_q <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            if_valid_q    <= if_valid_d;
            if_instr_q    <= if_instr_d;
            if_pc_q       <= if_pc_d;
            fault_q       <= fault_d;
            fetch_count_q <= fetch_count_d;
        end
    end

    assign pc          = pc_q;
    assign if_valid    = if_valid_q;
    assign if_instr    = if_instr_q;
    assign if_pc       = if_pc_q;
    assign halted      = (state_q == S_HALT);
    assign fault       = fault_q;
    assign fetch_count = fetch_count_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch: directed test-plan scenarios followed by randomized
// traffic, all compared against a behavioural model of the fetch rules.
module tb_instruction_fetch;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] pc;
    logic [15:0] instruction;
    logic        redirect_valid;
    logic [15:0] redirect_pc;
    logic        if_valid;
    logic [15:0] if_instr;
    logic [15:0] if_pc;
    logic        id_ready;
    logic        halted;
    logic        fault;
    logic [15:0] fetch_count;

    logic [15:0] rom [0:15];

    int n_checks;
    int n_fail;

    // Behavioural model: mode 0 = idle, 1 = running, 2 = halted.
    int m_mode;
    int m_pc;
    int m_vld;
    int m_instr;
    int m_ipc;
    int m_fault;
    int m_cnt;

    instruction_fetch dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .pc             (pc),
        .instruction    (instruction),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .if_valid       (if_valid),
        .if_instr       (if_instr),
        .if_pc          (if_pc),
        .id_ready       (id_ready),
        .halted         (halted),
        .fault          (fault),
        .fetch_count    (fetch_count)
    );

    // Combinational ROM; out-of-range addresses return a marker word.
    assign instruction = (pc < 16'd16) ? rom[pc[3:0]] : 16'hDEAD;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode  = 0;
        m_pc    = 0;
        m_vld   = 0;
        m_instr = 0;
        m_ipc   = 0;
        m_fault = 0;
        m_cnt   = 0;
    endtask

    task automatic compare_model();
        check_eq("pc", 32'(pc), 32'(m_pc));
        check_eq("if_valid", 32'(if_valid), 32'(m_vld));
        check_eq("halted", 32'(halted), 32'(m_mode == 2));
        check_eq("fault", 32'(fault), 32'(m_fault));
        check_eq("fetch_count", 32'(fetch_count), 32'(m_cnt));
        if (m_vld != 0) begin
            check_eq("if_pc", 32'(if_pc), 32'(m_ipc));
            check_eq("if_instr", 32'(if_instr), 32'(m_instr));
        end
    endtask

    // One clock: drive inputs after the falling edge, advance the model by the
    // fetch rules, then compare just after the rising edge.
    task automatic step(input logic st, input logic rdy, input logic rv, input logic [15:0] rpc);
        int word;
        int xfer;
        @(negedge clk);
        start          = st;
        id_ready       = rdy;
        redirect_valid = rv;
        redirect_pc    = rpc;
        xfer = (m_vld != 0 && rdy) ? 1 : 0;
        if (m_mode == 1) begin
            if (rv) begin
                m_pc  = int'(rpc);
                m_vld = 0;
            end else if (m_pc >= 16) begin
                m_fault = 1;
                m_mode  = 2;
                if (xfer != 0) m_vld = 0;
            end else if (m_vld == 0 || rdy) begin
                word    = int'(rom[m_pc]);
                m_instr = word;
                m_ipc   = m_pc;
                m_vld   = 1;
                if (m_cnt < 65535) m_cnt++;
                if (word == 16'hFFFF) m_mode = 2;
                else m_pc = (m_pc + 1) % 65536;
            end
        end else begin
            if (st) begin
                m_mode  = 1;
                m_pc    = 0;
                m_fault = 0;
                m_vld   = 0;
            end else if (xfer != 0) begin
                m_vld = 0;
            end
        end
        @(posedge clk);
        #1;
        compare_model();
    endtask

    task automatic check_reset_values(input string tag);
        check_eq({tag, "_pc"}, 32'(pc), 32'h0);
        check_eq({tag, "_if_valid"}, 32'(if_valid), 32'h0);
        check_eq({tag, "_if_instr"}, 32'(if_instr), 32'h0);
        check_eq({tag, "_if_pc"}, 32'(if_pc), 32'h0);
        check_eq({tag, "_halted"}, 32'(halted), 32'h0);
        check_eq({tag, "_fault"}, 32'(fault), 32'h0);
        check_eq({tag, "_fetch_count"}, 32'(fetch_count), 32'h0);
    endtask

    initial begin
        logic [15:0] line_words [0:3];
        int          saved_cnt;
        n_checks       = 0;
        n_fail         = 0;
        rst_n          = 1'b0;
        start          = 1'b0;
        id_ready       = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 16'h0;
        line_words[0] = 16'h1111;
        line_words[1] = 16'h2222;
        line_words[2] = 16'h3333;
        line_words[3] = 16'hFFFF;
        for (int i = 0; i < 16; i++) rom[i] = 16'h1000 + 16'(i);
        for (int i = 0; i < 4; i++) rom[i] = line_words[i];
        model_reset();

        // Reset state.
        #12;
        check_reset_values("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Straight line: start, then one word per cycle until the halt word.
        step(1'b1, 1'b1, 1'b0, 16'h0);
        check_eq("start_pc", 32'(pc), 32'h0);
        check_eq("start_valid", 32'(if_valid), 32'h0);
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b1, 1'b0, 16'h0);
            check_eq("line_instr", 32'(if_instr), 32'(line_words[i]));
            check_eq("line_if_pc", 32'(if_pc), 32'(i));
        end
        check_eq("line_halted", 32'(halted), 32'h1);
        check_eq("line_count", 32'(fetch_count), 32'd4);
        step(1'b0, 1'b1, 1'b0, 16'h0);
        check_eq("line_pc_hold", 32'(pc), 32'd3);
        check_eq("line_drained", 32'(if_valid), 32'h0);

        // Backpressure after the first fetch.
        step(1'b1, 1'b1, 1'b0, 16'h0);
        check_eq("restart_count_kept", 32'(fetch_count), 32'd4);
        step(1'b0, 1'b1, 1'b0, 16'h0);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 1'b0, 16'h0);
            check_eq("bp_instr", 32'(if_instr), 32'h1111);
            check_eq("bp_if_pc", 32'(if_pc), 32'h0);
            check_eq("bp_valid", 32'(if_valid), 32'h1);
            check_eq("bp_pc", 32'(pc), 32'h1);
        end
        step(1'b0, 1'b1, 1'b0, 16'h0);
        check_eq("bp_resume", 32'(if_instr), 32'h2222);

        // Redirect while the slot holds pc=2.
        step(1'b0, 1'b1, 1'b0, 16'h0);
        check_eq("rd_slot_pc", 32'(if_pc), 32'h2);
        step(1'b0, 1'b1, 1'b1, 16'd8);
        check_eq("rd_flush", 32'(if_valid), 32'h0);
        step(1'b0, 1'b1, 1'b0, 16'h0);
        check_eq("rd_target_pc", 32'(if_pc), 32'd8);
        check_eq("rd_target_instr", 32'(if_instr), 32'h1008);
        // Redirect while stalled: flush still happens.
        step(1'b0, 1'b0, 1'b1, 16'd5);
        check_eq("rd_stall_flush", 32'(if_valid), 32'h0);
        step(1'b0, 1'b1, 1'b0, 16'h0);
        check_eq("rd_stall_target", 32'(if_pc), 32'd5);

        // Fault on an out-of-range redirect target.
        step(1'b0, 1'b1, 1'b1, 16'd16);
        saved_cnt = m_cnt;
        step(1'b0, 1'b1, 1'b0, 16'h0);
        check_eq("fault_set", 32'(fault), 32'h1);
        check_eq("fault_halted", 32'(halted), 32'h1);
        check_eq("fault_no_load", 32'(if_valid), 32'h0);
        check_eq("fault_count", 32'(fetch_count), 32'(saved_cnt));
        step(1'b0, 1'b1, 1'b1, 16'd8);
        check_eq("halt_ignores_redirect", 32'(pc), 32'd16);
        step(1'b1, 1'b1, 1'b0, 16'h0);
        check_eq("fault_cleared", 32'(fault), 32'h0);
        check_eq("fault_restart_pc", 32'(pc), 32'h0);
        step(1'b0, 1'b1, 1'b0, 16'h0);
        check_eq("fault_restart_fetch", 32'(if_pc), 32'h0);
        // start in RUN is ignored.
        step(1'b1, 1'b1, 1'b0, 16'h0);
        check_eq("run_ignores_start", 32'(pc), 32'd2);

        // Reset between edges while stalled with a valid slot.
        step(1'b0, 1'b0, 1'b0, 16'h0);
        check_eq("pre_reset_valid", 32'(if_valid), 32'h1);
        #1;
        rst_n = 1'b0;
        #1;
        check_reset_values("async_reset");
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, 1'b1, 16'd9);
        end
        check_eq("idle_ignores_redirect", 32'(pc), 32'h0);

        // Randomized traffic.
        for (int i = 0; i < 16; i++) begin
            if ($urandom_range(0, 11) == 0) rom[i] = 16'hFFFF;
            else rom[i] = 16'($urandom_range(0, 16'hFFFE));
        end
        for (int n = 0; n < 3000; n++) begin
            logic st;
            logic rdy;
            logic rv;
            logic [15:0] rpc;
            st  = (m_mode != 1) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 19) == 0);
            rdy = ($urandom_range(0, 3) != 0);
            rv  = ($urandom_range(0, 7) == 0);
            rpc = 16'($urandom_range(0, 17));
            step(st, rdy, rv, rpc);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
